// File: rtl/tempo_pkg.sv
// tempo_pkg: shared state encoding, default tempo constants and the
// saturating step helper used by the beat-timer sequencing controller.
package tempo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] DEFAULT_LOAD = 9'd64;
  localparam logic [8:0] STEP         = 9'd16;
  localparam logic [8:0] MIN_LOAD     = 9'd16;
  localparam logic [8:0] MAX_LOAD     = 9'd496;

  // One saturating tempo step. The sum and the lower-bound test are done
  // in 10 bits so a value near 511 plus the step never wraps, and a value
  // below the step never underflows.
  function automatic logic [8:0] sat_step(
    input logic [8:0] cur,
    input logic       up,
    input logic [8:0] step,
    input logic [8:0] min_load,
    input logic [8:0] max_load
  );
    logic [9:0] sum;
    logic [9:0] floor_lim;
    sum       = {1'b0, cur} + {1'b0, step};
    floor_lim = {1'b0, min_load} + {1'b0, step};
    if (up) begin
      sat_step = (sum > {1'b0, max_load}) ? max_load : sum[8:0];
    end else begin
      sat_step = ({1'b0, cur} < floor_lim) ? min_load : (cur - step);
    end
  endfunction

endpackage

// File: rtl/tempo_reg.sv
// tempo_reg: saturating up/down tempo (timer load) register.
// Only instantiated by tempo_ctrl when TEMPO_ADJ_EN is defined.
module tempo_reg #(
  parameter logic [8:0] DEFAULT_LOAD = tempo_pkg::DEFAULT_LOAD,
  parameter logic [8:0] STEP         = tempo_pkg::STEP,
  parameter logic [8:0] MIN_LOAD     = tempo_pkg::MIN_LOAD,
  parameter logic [8:0] MAX_LOAD     = tempo_pkg::MAX_LOAD
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       faster,
  input  logic       slower,
  output logic [8:0] load_value
);
  import tempo_pkg::*;

  logic [8:0] load_reg;
  logic [8:0] load_next;

  // Next tempo: a lone faster/slower pulse steps with saturation; both or neither hold.
  always_comb begin
    load_next = load_reg;
    if (faster && !slower) begin
      load_next = sat_step(load_reg, 1'b0, STEP, MIN_LOAD, MAX_LOAD);
    end else if (slower && !faster) begin
      load_next = sat_step(load_reg, 1'b1, STEP, MIN_LOAD, MAX_LOAD);
    end
  end

  // Tempo register with synchronous active-low reset to the default tempo.
  always_ff @(posedge clock) begin
    if (!reset) begin
      load_reg <= DEFAULT_LOAD;
    end else begin
      load_reg <= load_next;
    end
  end

  assign load_value = load_reg;

endmodule

// File: rtl/tempo_ctrl.sv
// tempo_ctrl: note sequencing for the beat timer. Accepts a note duration
// over valid/ready, enables the timer while playing, counts beat pulses and
// pulses note_done when the note ends. Tempo adjustment (faster/slower) is
// built only when the TEMPO_ADJ_EN macro is defined; otherwise load_value
// is fixed at DEFAULT_LOAD.
module tempo_ctrl #(
  parameter logic [8:0] DEFAULT_LOAD = tempo_pkg::DEFAULT_LOAD,
  parameter logic [8:0] STEP         = tempo_pkg::STEP,
  parameter logic [8:0] MIN_LOAD     = tempo_pkg::MIN_LOAD,
  parameter logic [8:0] MAX_LOAD     = tempo_pkg::MAX_LOAD,
  parameter int         DUR_W        = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             play,
  input  logic             faster,
  input  logic             slower,
  input  logic [DUR_W-1:0] dur,
  input  logic             dur_valid,
  output logic             dur_ready,
  input  logic             beat,
  output logic             count_en,
  output logic [8:0]       load_value,
  output logic [DUR_W-1:0] beats_left,
  output logic             note_done
);
  import tempo_pkg::*;

  localparam logic [DUR_W-1:0] ONE_BEAT = DUR_W'(1);

  state_t           state_reg;
  state_t           state_next;
  logic [DUR_W-1:0] beats_left_reg;
  logic [DUR_W-1:0] beats_left_next;

  // Next-state, beat counter and Moore outputs; all defaults assigned first.
  always_comb begin
    state_next      = state_reg;
    beats_left_next = beats_left_reg;
    dur_ready       = 1'b0;
    count_en        = 1'b0;
    note_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        dur_ready = 1'b1;
        if (dur_valid) begin
          // A zero-length note still plays for one beat.
          beats_left_next = (dur == '0) ? ONE_BEAT : dur;
          state_next      = RUN;
        end
      end
      RUN: begin
        count_en = 1'b1;
        if (beat && (beats_left_reg == ONE_BEAT)) begin
          // Final beat wins over a simultaneous pause request.
          beats_left_next = '0;
          state_next      = DONE;
        end else begin
          if (beat) begin
            beats_left_next = beats_left_reg - ONE_BEAT;
          end
          if (!play) begin
            state_next = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (play) begin
          state_next = RUN;
        end
      end
      DONE: begin
        note_done  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and beat-counter registers; reset aborts any note silently.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      beats_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      beats_left_reg <= beats_left_next;
    end
  end

  assign beats_left = beats_left_reg;

`ifdef TEMPO_ADJ_EN
  tempo_reg #(
    .DEFAULT_LOAD (DEFAULT_LOAD),
    .STEP         (STEP),
    .MIN_LOAD     (MIN_LOAD),
    .MAX_LOAD     (MAX_LOAD)
  ) u_tempo_reg (
    .clock      (clock),
    .reset      (reset),
    .faster     (faster),
    .slower     (slower),
    .load_value (load_value)
  );
`else
  // Fixed tempo: faster/slower have no effect in this build.
  logic unused_tempo_req;
  assign unused_tempo_req = faster | slower;
  assign load_value       = DEFAULT_LOAD;
`endif

endmodule

// File: tb/tb_tempo_ctrl.sv
// tb_tempo_ctrl: directed bench for tempo_ctrl with a behavioural reference
// model checked every cycle, plus literal expectations along the way.
module tb_tempo_ctrl;

  localparam int DUR_W = 6;
`ifdef TEMPO_ADJ_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             play;
  logic             faster;
  logic             slower;
  logic [DUR_W-1:0] dur;
  logic             dur_valid;
  logic             dur_ready;
  logic             beat;
  logic             count_en;
  logic [8:0]       load_value;
  logic [DUR_W-1:0] beats_left;
  logic             note_done;

  int n_checks = 0;
  int n_fail   = 0;

  tempo_ctrl #(.DUR_W(DUR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .play       (play),
    .faster     (faster),
    .slower     (slower),
    .dur        (dur),
    .dur_valid  (dur_valid),
    .dur_ready  (dur_ready),
    .beat       (beat),
    .count_en   (count_en),
    .load_value (load_value),
    .beats_left (beats_left),
    .note_done  (note_done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a note is either absent, playing, paused, or just finished.
  bit m_valid  = 1'b0;
  bit m_busy   = 1'b0;
  bit m_paused = 1'b0;
  bit m_done   = 1'b0;
  int m_left   = 0;
  int m_load   = 64;

  always @(posedge clock) begin
    m_valid <= 1'b1;
    if (!reset) begin
      m_busy   <= 1'b0;
      m_paused <= 1'b0;
      m_done   <= 1'b0;
      m_left   <= 0;
      m_load   <= 64;
    end else begin
      if (m_done) begin
        m_done <= 1'b0;
      end else if (!m_busy) begin
        if (dur_valid) begin
          m_busy   <= 1'b1;
          m_paused <= 1'b0;
          m_left   <= (int'(dur) == 0) ? 1 : int'(dur);
        end
      end else if (m_paused) begin
        if (play) m_paused <= 1'b0;
      end else begin
        if (beat && m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_left <= 0;
        end else begin
          if (beat) m_left <= m_left - 1;
          if (!play) m_paused <= 1'b1;
        end
      end
      if (ADJ && faster && !slower) m_load <= (m_load - 16 < 16) ? 16 : m_load - 16;
      if (ADJ && slower && !faster) m_load <= (m_load + 16 > 496) ? 496 : m_load + 16;
    end
  end

  // Every-cycle comparison of all outputs against the model, mid-cycle.
  always @(negedge clock) begin
    if (m_valid) begin
      chk("dur_ready",  int'(dur_ready),  int'(!m_busy && !m_done));
      chk("count_en",   int'(count_en),   int'(m_busy && !m_paused));
      chk("note_done",  int'(note_done),  int'(m_done));
      chk("beats_left", int'(beats_left), m_left);
      chk("load_value", int'(load_value), m_load);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_beat(input int n);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
    end
  endtask

  task automatic accept(input int d);
    dur       = DUR_W'(d);
    dur_valid = 1'b1;
    tick();
    dur_valid = 1'b0;
    dur       = '0;
  endtask

  initial begin
    reset = 1'b0; play = 1'b1; faster = 1'b0; slower = 1'b0;
    dur = '0; dur_valid = 1'b0; beat = 1'b0;
    tick(); tick();
    chk("rst_dur_ready",  int'(dur_ready),  1);
    chk("rst_count_en",   int'(count_en),   0);
    chk("rst_beats_left", int'(beats_left), 0);
    chk("rst_load",       int'(load_value), 64);
    chk("rst_note_done",  int'(note_done),  0);
    reset = 1'b1;
    tick();

    // Three-beat note
    accept(3);
    chk("n3_count_en",  int'(count_en),   1);
    chk("n3_dur_ready", int'(dur_ready),  0);
    chk("n3_left3",     int'(beats_left), 3);
    tick();
    pulse_beat(1); chk("n3_left2", int'(beats_left), 2);
    pulse_beat(1); chk("n3_left1", int'(beats_left), 1);
    pulse_beat(1);
    chk("n3_done",      int'(note_done),  1);
    chk("n3_done_left", int'(beats_left), 0);
    chk("n3_done_rdy",  int'(dur_ready),  0);
    tick();
    chk("n3_idle_rdy",  int'(dur_ready),  1);
    chk("n3_idle_done", int'(note_done),  0);

    // Tempo saturation
    slower = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("slow7", int'(load_value), ADJ ? 176 : 64);
    for (int i = 0; i < 40; i++) tick();
    chk("slow_sat", int'(load_value), ADJ ? 496 : 64);
    slower = 1'b0;
    faster = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("fast_sat", int'(load_value), ADJ ? 16 : 64);
    faster = 1'b0;
    slower = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    faster = 1'b1;
    tick();
    chk("both_hold", int'(load_value), 64);
    faster = 1'b0;
    slower = 1'b0;

    // Pause with a simultaneous beat
    accept(4);
    pulse_beat(2);
    chk("p_left2", int'(beats_left), 2);
    play = 1'b0;
    pulse_beat(1);
    chk("p_left1",   int'(beats_left), 1);
    chk("p_cnt_off", int'(count_en),   0);
    pulse_beat(2);
    chk("p_ignored", int'(beats_left), 1);
    chk("p_no_done", int'(note_done),  0);
    play = 1'b1;
    tick();
    chk("p_resume", int'(count_en), 1);
    pulse_beat(1);
    chk("p_done", int'(note_done), 1);
    tick();

    // Zero duration and beats while idle
    accept(0);
    chk("z_left1", int'(beats_left), 1);
    pulse_beat(1);
    chk("z_done", int'(note_done), 1);
    tick();
    pulse_beat(3);
    chk("idle_beat_rdy",  int'(dur_ready),  1);
    chk("idle_beat_left", int'(beats_left), 0);

    // Reset mid-note
    slower = 1'b1;
    tick();
    slower = 1'b0;
    chk("pre_rst_load", int'(load_value), ADJ ? 80 : 64);
    accept(5);
    chk("mid_left5", int'(beats_left), 5);
    reset = 1'b0;
    tick();
    chk("mid_rst_left", int'(beats_left), 0);
    chk("mid_rst_rdy",  int'(dur_ready),  1);
    chk("mid_rst_load", int'(load_value), 64);
    chk("mid_rst_done", int'(note_done),  0);
    reset = 1'b1;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tempo_ctrl.md
# tempo_ctrl

Sequencing controller for the beat `timer` in the music-player datapath.
- Owns the timer's 9-bit `load_value` (tempo) and its `count_en`.
- Applies faster/slower tempo requests.
- Accepts note durations from the note player over a valid/ready handshake, counts timer beat pulses, and signals note completion.

## Interface
Parameters:
- `DEFAULT_LOAD`, 9'd64: tempo load value after reset.
- `STEP`, 9'd16: tempo change per faster/slower pulse.
- `MIN_LOAD`, 9'd16: fastest tempo (smallest load).
- `MAX_LOAD`, 9'd496: slowest tempo (largest load).
- `DUR_W`, 6: note duration width, in beats.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `play` in 1: level. 1 = run, 0 = pause.
- `faster` in 1: one-cycle pulse; decreases `load_value` by `STEP`.
- `slower` in 1: one-cycle pulse; increases `load_value` by `STEP`.
- `dur` in DUR_W: note length in beats.
- `dur_valid` in 1: `dur` is valid.
- `dur_ready` out 1: controller accepts a duration.
- `beat` in 1: one-cycle pulse from the timer `out`.
- `count_en` out 1: timer count enable.
- `load_value` out 9: timer reload value.
- `beats_left` out DUR_W: remaining beats of the current note.
- `note_done` out 1: one-cycle pulse when a note completes.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - `dur_ready`=1, `count_en`=0.
  - On `dur_valid`&`dur_ready`: capture `beats_left` = (`dur`==0 ? 1 : `dur`), then go to RUN.
- RUN:
  - `count_en`=1.
  - On `beat`:
    - `beats_left`==1 → DONE.
    - Otherwise `beats_left` decrements.
  - `play`=0 → PAUSE. A `beat` in the same cycle is still counted; if it is the final beat, DONE takes priority.
- PAUSE: `count_en`=0; `beats_left` held; `beat` ignored. `play`=1 → RUN.
- DONE: `note_done`=1 for this cycle only, `beats_left`=0, `count_en`=0; then → IDLE.
- `beat` in IDLE or DONE is ignored.
- Tempo register, independent of the state machine:
  - `faster` only: `load_value` = max(`load_value` − `STEP`, `MIN_LOAD`).
  - `slower` only: `load_value` = min(`load_value` + `STEP`, `MAX_LOAD`).
  - Both or neither: no change.
  - Arithmetic is 10-bit internally, so adding `STEP` to a value near 511 never wraps.
  - Tempo changes apply in every state; the timer picks up the new value at its next reload.

## Timing
- Reset (`reset`=0 at an edge), values after that edge:
  - State IDLE; `dur_ready`=1; `count_en`=0; `note_done`=0; `beats_left`=0; `load_value`=`DEFAULT_LOAD`.
- Reset mid-note aborts the note with no `note_done`.
- Handshake accepted at edge N: `count_en`=1 and `dur_ready`=0 from N+1.
- Final `beat` sampled at edge M: `note_done`=1 during cycle M+1 (DONE); `dur_ready`=1 from M+2 (IDLE).
- Minimum gap between `note_done` and the next accept is one cycle.
- `dur` is sampled only on the accept edge.
- `faster`/`slower` at edge K: new `load_value` is visible from K+1.
- `play` takes effect at the next edge; `count_en` drops one cycle after `play` falls.

## Configuration
- `TEMPO_ADJ_EN` defined: faster/slower tempo adjustment as described above.
- `TEMPO_ADJ_EN` undefined:
  - `faster`/`slower` are ignored.
  - `load_value` is constant at `DEFAULT_LOAD`.
  - The tempo register and saturation logic are not synthesized.
  - All other behaviour is identical.

## Structure
- Shared package `tempo_pkg`:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - Default tempo constants: `DEFAULT_LOAD`, `STEP`, `MIN_LOAD`, `MAX_LOAD`.
- One sub-module, `tempo_reg`: saturating up/down load register with reset to `DEFAULT_LOAD`. It is instantiated only under `TEMPO_ADJ_EN`.
- The state machine and beat counter live in `tempo_ctrl`.

## Test plan
- Reset, then `dur`=3 with `dur_valid` and `play`=1, and 3 `beat` pulses → `count_en`=1 after accept, `beats_left` goes 3→2→1, `note_done` one cycle after the 3rd beat, `dur_ready`=1 one cycle after that.
- 7 `slower` pulses from reset → `load_value` 64→176. Then 40 `slower` pulses → saturates at 496. Then 40 `faster` pulses → saturates at 16.
- `faster` and `slower` asserted in the same cycle → `load_value` unchanged.
- `dur`=4, 2 beats, `play`=0 together with a beat → `beats_left`=1, PAUSE, `count_en`=0. Further beats are ignored. `play`=1 then one beat → `note_done`.
- `dur`=0 accepted, one `beat` → `note_done`. `beat` pulses in IDLE → no state change.
- `reset`=0 mid-note with `beats_left`=5 → next cycle IDLE, `beats_left`=0, `load_value`=64, no `note_done`.
